// File: rtl/rns_mod_alu_seq.sv
// Modular add/sub/mul engine for a single RNS channel. Multiplication runs one
// MSB-first double-and-add step per clock. The result buses are one-hot-valued for an OR-style 3:1 mux.
module rns_mod_alu_seq #(
    parameter int WIDTH   = 7,
    parameter int MODULUS = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] add,
    output logic [WIDTH-1:0] sub,
    output logic [WIDTH-1:0] mul,
    output logic             s0,
    output logic             s1
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]   MOD_X = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] MOD_N = MODULUS[WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        MUL    = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_dbl;
    logic [WIDTH-1:0]   acc_next;
    logic               accept;

    // Single conditional subtract; valid because every caller keeps s < 2*M.
    function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] s);
        logic [WIDTH:0] diff;
        diff = s - MOD_X;
        return (s >= MOD_X) ? diff[WIDTH-1:0] : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return mod_reduce({1'b0, x} + {1'b0, y});
    endfunction

    // The wrapped difference plus M always fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return (x >= y) ? (x - y) : (x - y + MOD_N);
    endfunction

    function automatic logic [WIDTH-1:0] mod_dbl(input logic [WIDTH-1:0] x);
        return mod_reduce({x, 1'b0});
    endfunction

    assign accept = (state == IDLE) && start;

    always_comb begin
        acc_dbl  = mod_dbl(acc);
        acc_next = acc_dbl;
        if (b_q[cnt]) begin
            acc_next = mod_add(acc_dbl, a_q);
        end
    end

    // Datapath registers: operand latches and multiply accumulator.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            a_q  <= mod_reduce({1'b0, a});
            b_q  <= mod_reduce({1'b0, b});
            acc  <= '0;
            cnt  <= CNT_W'(WIDTH - 1);
        end else if (state == MUL) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            add   <= '0;
            sub   <= '0;
            mul   <= '0;
            s0    <= 1'b0;
            s1    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= (op == 2'b10) ? MUL : ADDSUB;
                    end
                end
                ADDSUB: begin
                    mul <= '0;
                    case (op_q)
                        2'b00: begin
                            add      <= mod_add(a_q, b_q);
                            sub      <= '0;
                            {s1, s0} <= 2'b00;
                        end
                        2'b01: begin
                            add      <= '0;
                            sub      <= mod_sub(a_q, b_q);
                            {s1, s0} <= 2'b01;
                        end
                        default: begin
                            add      <= '0;
                            sub      <= '0;
                            {s1, s0} <= 2'b11;
                        end
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                MUL: begin
                    if (cnt == '0) begin
                        mul      <= acc_next;
                        add      <= '0;
                        sub      <= '0;
                        {s1, s0} <= 2'b10;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rns_mod_alu_seq.sv
// Directed bench for rns_mod_alu_seq (WIDTH=7, MODULUS=127) with hand-computed residues.
module tb_rns_mod_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [6:0] a;
    logic [6:0] b;
    logic       busy;
    logic       done;
    logic [6:0] add;
    logic [6:0] sub;
    logic [6:0] mul;
    logic       s0;
    logic       s1;

    int checks = 0;
    int errors = 0;

    rns_mod_alu_seq #(.WIDTH(7), .MODULUS(127)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .add(add), .sub(sub), .mul(mul),
        .s0(s0), .s1(s1)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until done (bounded at 20).
    task automatic do_op(input logic [1:0] o, input logic [6:0] x, input logic [6:0] y,
                         output int lat, output logic busy_seen);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_seen = busy;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if ({add, sub, mul, s1, s0} !== 23'd0) begin
            errors++; $display("FAIL reset_outputs: add=%0d sub=%0d mul=%0d sel=%b expected all 0", add, sub, mul, {s1, s0});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat; logic bs;
        do_op(2'b00, 7'd100, 7'd50, lat, bs);
        checks++;
        if (bs !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", bs); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
        checks++;
        if (add !== 7'd23) begin errors++; $display("FAIL add_value: got %0d expected 23", add); end
        checks++;
        if ({sub, mul, s1, s0} !== 16'd0) begin
            errors++; $display("FAIL add_others: sub=%0d mul=%0d sel=%b expected 0 0 00", sub, mul, {s1, s0});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_sub();
        int lat; logic bs;
        do_op(2'b01, 7'd5, 7'd9, lat, bs);
        checks++;
        if (sub !== 7'd123) begin errors++; $display("FAIL sub_wrap: got %0d expected 123", sub); end
        checks++;
        if ({s1, s0} !== 2'b01) begin errors++; $display("FAIL sub_sel: got %b expected 01", {s1, s0}); end
        checks++;
        if ({add, mul} !== 14'd0) begin errors++; $display("FAIL sub_others: add=%0d mul=%0d expected 0 0", add, mul); end
        do_op(2'b01, 7'd9, 7'd5, lat, bs);
        checks++;
        if (sub !== 7'd4) begin errors++; $display("FAIL sub_plain: got %0d expected 4", sub); end
    endtask

    task automatic test_mul();
        int lat; logic bs;
        do_op(2'b10, 7'd100, 7'd100, lat, bs);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL mul_latency: got %0d expected 7", lat); end
        checks++;
        if (mul !== 7'd94) begin errors++; $display("FAIL mul_100x100: got %0d expected 94", mul); end
        checks++;
        if ({add, sub} !== 14'd0) begin errors++; $display("FAIL mul_others: add=%0d sub=%0d expected 0 0", add, sub); end
        checks++;
        if ({s1, s0} !== 2'b10) begin errors++; $display("FAIL mul_sel: got %b expected 10", {s1, s0}); end
        do_op(2'b10, 7'd126, 7'd126, lat, bs);
        checks++;
        if (mul !== 7'd1) begin errors++; $display("FAIL mul_126x126: got %0d expected 1", mul); end
        do_op(2'b10, 7'd0, 7'd77, lat, bs);
        checks++;
        if (mul !== 7'd0) begin errors++; $display("FAIL mul_0x77: got %0d expected 0", mul); end
        do_op(2'b10, 7'd13, 7'd11, lat, bs);
        checks++;
        if (mul !== 7'd16) begin errors++; $display("FAIL mul_13x11: got %0d expected 16", mul); end
    endtask

    task automatic test_reduce_clear();
        int lat; logic bs;
        do_op(2'b00, 7'd127, 7'd5, lat, bs);
        checks++;
        if (add !== 7'd5) begin errors++; $display("FAIL reduce_add: got %0d expected 5", add); end
        do_op(2'b01, 7'd3, 7'd127, lat, bs);
        checks++;
        if (sub !== 7'd3) begin errors++; $display("FAIL reduce_sub: got %0d expected 3", sub); end
        do_op(2'b11, 7'd40, 7'd41, lat, bs);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL clear_latency: got %0d expected 1", lat); end
        checks++;
        if ({add, sub, mul, s1, s0} !== {21'd0, 2'b11}) begin
            errors++; $display("FAIL clear_outputs: add=%0d sub=%0d mul=%0d sel=%b expected 0 0 0 11", add, sub, mul, {s1, s0});
        end
    endtask

    task automatic test_busy_rules();
        int done_cnt; int done_at; int lat; logic bs;
        op = 2'b10; a = 7'd10; b = 7'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b00; a = 7'd1; b = 7'd1;
        done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (i == 4) start = 1'b0;
            if (done === 1'b1) begin done_cnt++; done_at = i; end
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1 || done_at != 7) begin
            errors++; $display("FAIL busy_ignore_done: got %0d pulses at edge %0d expected 1 at 7", done_cnt, done_at);
        end
        checks++;
        if (mul !== 7'd30) begin errors++; $display("FAIL busy_ignore_mul: got %0d expected 30", mul); end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, mul, add} !== {2'b00, 7'd30, 7'd0}) begin
            errors++; $display("FAIL busy_ignore_after: busy=%b done=%b mul=%0d add=%0d expected 0 0 30 0", busy, done, mul, add);
        end
        do_op(2'b00, 7'd3, 7'd4, lat, bs);
        op = 2'b01; a = 7'd20; b = 7'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL done_cycle_accept: busy got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++;
        if ({done, sub, s1, s0} !== {1'b1, 7'd14, 2'b01}) begin
            errors++; $display("FAIL done_cycle_second: done=%b sub=%0d sel=%b expected 1 14 01", done, sub, {s1, s0});
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen; int lat; logic bs;
        op = 2'b10; a = 7'd100; b = 7'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, add, sub, mul, s1, s0} !== 25'd0) begin
            errors++; $display("FAIL reset_mid_outputs: busy=%b done=%b add=%0d sub=%0d mul=%0d sel=%b expected all 0",
                                busy, done, add, sub, mul, {s1, s0});
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen); end
        do_op(2'b00, 7'd3, 7'd4, lat, bs);
        checks++;
        if (add !== 7'd7 || lat != 1) begin
            errors++; $display("FAIL reset_mid_fresh_add: add=%0d lat=%0d expected 7 1", add, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_reduce_clear();
        test_busy_rules();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
